button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_pkg.sv | 31 +++
 rtl/button_conditioner_sync_2ff.sv | 31 +++
 rtl/button_conditioner.sv | 159 +++++++++++++++
 tb/tb_button_conditioner.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared constants and FSM encoding for the push-button conditioner (50 MHz reference clock).
// BUTTON_AUTOREPEAT_EN adds the REPEAT state to the encoding.
package button_pkg;

  localparam int unsigned CLK_HZ              = 50_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;  // 10 ms
  localparam int unsigned DEF_REPEAT_DELAY    = CLK_HZ / 2;    // 500 ms
  localparam int unsigned DEF_REPEAT_PERIOD   = CLK_HZ / 10;   // 100 ms
  localparam int unsigned DEF_CNT_W           = 26;

  localparam logic SYNC_RST_VAL = 1'b1;

  typedef enum logic [2:0] {
    ST_RELEASED   = 3'd0,
    ST_PRESS_DB   = 3'd1,
    ST_HELD       = 3'd2,
`ifdef BUTTON_AUTOREPEAT_EN
    ST_REPEAT     = 3'd3,
`endif
    ST_RELEASE_DB = 3'd4
  } btn_state_e;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_conditioner_sync_2ff.sv
// Two-flop synchronizer for the raw asynchronous button input; resets to the idle (high) level.
module sync_2ff
  import button_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = i_d;
    sync_d = meta_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta_q <= SYNC_RST_VAL;
      sync_q <= SYNC_RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces an active-low push-button and produces level, press/release pulses and optional auto-repeat.
// Auto-repeat is built only when BUTTON_AUTOREPEAT_EN is defined.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic i_CLK,
  input  logic i_RST,
  input  logic i_BTN_n,
  output logic o_BTN_n,
  output logic o_HELD,
  output logic o_PRESS,
  output logic o_RELEASE
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  // Counter saturates so a long HELD without auto-repeat can never wrap.
  localparam logic [CNT_W-1:0] CNT_LIMIT =
    CNT_W'(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD));
`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST   = CNT_W'(REPEAT_PERIOD - 1);
`endif

  logic s;

  sync_2ff u_sync (
    .i_clk (i_CLK),
    .i_rst (i_RST),
    .i_d   (i_BTN_n),
    .o_q   (s)
  );

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             btn_n_q, btn_n_d;
  logic             held_q, held_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             blip_q, blip_d;

  always_comb begin
    cnt_inc   = (cnt_q >= CNT_LIMIT) ? cnt_q : cnt_q + CNT_ONE;
    state_d   = state_q;
    cnt_d     = cnt_inc;
    btn_n_d   = btn_n_q;
    held_d    = held_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    blip_d    = 1'b0;

    // A repeat event raises o_BTN_n for one cycle; the press pulse lands as it drops back.
    if (blip_q) begin
      btn_n_d = 1'b0;
      press_d = 1'b1;
    end

    unique case (state_q)
      ST_RELEASED: begin
        cnt_d = '0;
        if (!s) begin
          state_d = ST_PRESS_DB;
        end
      end

      ST_PRESS_DB: begin
        if (s) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          press_d = 1'b1;
          btn_n_d = 1'b0;
          held_d  = 1'b1;
        end
      end

      ST_HELD: begin
        if (s) begin
          state_d = ST_RELEASE_DB;
          cnt_d   = '0;
        end
`ifdef BUTTON_AUTOREPEAT_EN
        else if (cnt_q == RD_LAST) begin
          state_d = ST_REPEAT;
          cnt_d   = '0;
          btn_n_d = 1'b1;
          blip_d  = 1'b1;
        end
`endif
      end

`ifdef BUTTON_AUTOREPEAT_EN
      ST_REPEAT: begin
        if (s) begin
          state_d = ST_RELEASE_DB;
          cnt_d   = '0;
        end else if (cnt_q == RP_LAST) begin
          cnt_d   = '0;
          btn_n_d = 1'b1;
          blip_d  = 1'b1;
        end
      end
`endif

      ST_RELEASE_DB: begin
        if (!s) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d   = ST_RELEASED;
          cnt_d     = '0;
          release_d = 1'b1;
          btn_n_d   = 1'b1;
          held_d    = 1'b0;
        end
      end

      default: begin
        state_d = ST_RELEASED;
        cnt_d   = '0;
        btn_n_d = 1'b1;
        held_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q   <= ST_RELEASED;
      cnt_q     <= '0;
      btn_n_q   <= 1'b1;
      held_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      blip_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      btn_n_q   <= btn_n_d;
      held_q    <= held_d;
      press_q   <= press_d;
      release_q <= release_d;
      blip_q    <= blip_d;
    end
  end

  assign o_BTN_n   = btn_n_q;
  assign o_HELD    = held_q;
  assign o_PRESS   = press_q;
  assign o_RELEASE = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: press latency, hold/repeat, glitchy release, bounce, reset.
// Repeat-specific expectations apply when BUTTON_AUTOREPEAT_EN is defined.
`timescale 1ns/1ps
module tb_button_conditioner;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 20;
  localparam int unsigned RP = 8;
  localparam int unsigned CW = 8;
`ifdef BUTTON_AUTOREPEAT_EN
  localparam int unsigned HOLD = 60;
`else
  localparam int unsigned HOLD = 200;
`endif

  logic clk = 1'b0;
  logic rst;
  logic btn_n;
  logic o_btn_n, o_held, o_press, o_release;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  int edge_no, presses, releases, btn_hi, btn_lo, held_drops, overlaps;
  int first_press, first_blip;

  button_conditioner #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .CNT_W           (CW)
  ) dut (
    .i_CLK     (clk),
    .i_RST     (rst),
    .i_BTN_n   (btn_n),
    .o_BTN_n   (o_btn_n),
    .o_HELD    (o_held),
    .o_PRESS   (o_press),
    .o_RELEASE (o_release)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic clear_stats();
    presses = 0; releases = 0; btn_hi = 0; btn_lo = 0; held_drops = 0;
    first_press = 0; first_blip = 0;
  endtask

  // One rising edge, then sample 1 ns later and accumulate output statistics.
  task automatic step();
    @(posedge clk);
    #1;
    edge_no++;
    if (o_press) begin
      presses++;
      if (first_press == 0) first_press = edge_no;
    end
    if (o_release) releases++;
    if (o_btn_n) begin
      btn_hi++;
      if (first_blip == 0) first_blip = edge_no;
    end else begin
      btn_lo++;
    end
    if (!o_held) held_drops++;
    if (o_press && o_release) overlaps++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    overlaps = 0;
    edge_no  = 0;
    clear_stats();
    rst   = 1'b1;
    btn_n = 1'b1;

    #12;
    check("rst_btn_n",   o_btn_n,   1);
    check("rst_held",    o_held,    0);
    check("rst_press",   o_press,   0);
    check("rst_release", o_release, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step();

    // Clean press: raw low sampled from edge 1, pulse expected after edge 7.
    edge_no = 0;
    clear_stats();
    btn_n = 1'b0;
    repeat (6) step();
    check("press_early", presses, 0);
    step();
    check("press_edge7", o_press, 1);
    check("press_btn_n", o_btn_n, 0);
    check("press_held",  o_held,  1);
    step();
    check("press_one_cycle", o_press, 0);

    // Keep holding through edge HOLD.
    clear_stats();
    repeat (HOLD - 8) step();
`ifdef BUTTON_AUTOREPEAT_EN
    check("rep_presses",     presses,     5);
    check("rep_blips",       btn_hi,      5);
    check("rep_first_blip",  first_blip,  27);
    check("rep_first_press", first_press, 28);
`else
    check("hold_presses", presses, 0);
    check("hold_btn_hi",  btn_hi,  0);
`endif
    check("hold_held", held_drops, 0);

    // Release with a 2-cycle low glitch, then clean release.
    clear_stats();
    btn_n = 1'b1;
    repeat (2) step();
    btn_n = 1'b0;
    repeat (2) step();
    btn_n = 1'b1;
    repeat (6) step();
    check("rel_glitch_pulses", presses + releases, 0);
    check("rel_glitch_btn_hi", btn_hi, 0);
    check("rel_glitch_held",   held_drops, 0);
    step();
    check("rel_pulse", o_release, 1);
    check("rel_btn_n", o_btn_n,   1);
    check("rel_held",  o_held,    0);
    step();
    check("rel_one_cycle", o_release, 0);

    // Bounce: low/high every 2 cycles for 20 cycles, then high.
    clear_stats();
    for (int i = 0; i < 5; i++) begin
      btn_n = 1'b0;
      repeat (2) step();
      btn_n = 1'b1;
      repeat (2) step();
    end
    repeat (10) step();
    check("bounce_press",   presses,  0);
    check("bounce_release", releases, 0);
    check("bounce_btn_lo",  btn_lo,   0);

    // Reset while holding (in REPEAT when auto-repeat is built).
    clear_stats();
    btn_n = 1'b0;
    repeat (30) step();
    check("pre_rst_btn_n", o_btn_n, 0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_btn_n",   o_btn_n,   1);
    check("mid_rst_held",    o_held,    0);
    check("mid_rst_press",   o_press,   0);
    check("mid_rst_release", o_release, 0);
    clear_stats();
    repeat (2) step();
    check("in_rst_pulses", presses + releases, 0);
    @(negedge clk);
    rst = 1'b0;
    edge_no = 0;
    clear_stats();
    repeat (6) step();
    check("rerst_press_early", presses + releases, 0);
    step();
    check("rerst_press_edge7", o_press, 1);
    check("rerst_held",        o_held,  1);

    check("press_release_overlap", overlaps, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
